// File: rtl/seg_display_ctrl.sv
// Eight-digit multiplexed seven-segment controller: serial double-dabble
// binary-to-BCD conversion of a 16-bit value plus prog/mode status digits.
//
// state    | meaning
// S_IDLE   | waiting for a strobe or pending word; display holds last result
// S_SHIFT  | 16 double-dabble iterations, one bit per cycle
// S_COMMIT | copy BCD result into the display digit registers
module seg_display_ctrl #(
   parameter int REFRESH = 50000
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        data_2_valid,
   input  logic [15:0] data_2,
   input  logic        gen_mod,
   input  logic [2:0]  prog,
   output logic [7:0]  an,
   output logic [7:0]  dec_cat,
   output logic        busy
);

   localparam int PW = (REFRESH > 2) ? $clog2(REFRESH) : 1;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_SHIFT  = 2'd1,
      S_COMMIT = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic [15:0] bin_q, bin_d;
   logic [19:0] bcd_q, bcd_d;
   logic [3:0]  cnt_q, cnt_d;
   logic        pend_v_q, pend_v_d;
   logic [15:0] pend_q, pend_d;
   logic [19:0] dig_q, dig_d;
   logic [PW-1:0] presc_q, presc_d;
   logic [2:0]  idx_q, idx_d;
   logic [7:0]  an_q, an_d;
   logic [7:0]  cat_q, cat_d;

   logic [18:0] bcd_adj;
   logic [3:0]  nib;
   logic [4:0]  code;
   logic        blank;
   logic [7:0]  seg;

   always_comb begin
      state_d  = state_q;
      bin_d    = bin_q;
      bcd_d    = bcd_q;
      cnt_d    = cnt_q;
      pend_v_d = pend_v_q;
      pend_d   = pend_q;
      dig_d    = dig_q;
      bcd_adj  = '0;
      nib      = '0;

      for (int n = 0; n < 4; n++) begin
         nib = bcd_q[4*n +: 4];
         bcd_adj[4*n +: 4] = (nib >= 4'd5) ? nib + 4'd3 : nib;
      end
      // Ten-thousands nibble is at most 3 before any shift, so it never needs the +3.
      bcd_adj[18:16] = bcd_q[18:16];

      case (state_q)
         S_IDLE: begin
            if (data_2_valid) begin
               bin_d    = data_2;
               bcd_d    = '0;
               cnt_d    = '0;
               pend_v_d = 1'b0;
               state_d  = S_SHIFT;
            end else if (pend_v_q) begin
               bin_d    = pend_q;
               bcd_d    = '0;
               cnt_d    = '0;
               pend_v_d = 1'b0;
               state_d  = S_SHIFT;
            end
         end
         S_SHIFT: begin
            {bcd_d, bin_d} = {bcd_adj, bin_q, 1'b0};
            cnt_d = cnt_q + 4'd1;
            if (cnt_q == 4'd15) state_d = S_COMMIT;
            if (data_2_valid) begin
               pend_v_d = 1'b1;
               pend_d   = data_2;
            end
         end
         S_COMMIT: begin
            dig_d   = bcd_q;
            state_d = S_IDLE;
            if (data_2_valid) begin
               pend_v_d = 1'b1;
               pend_d   = data_2;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      presc_d = presc_q + 1'b1;
      idx_d   = idx_q;
      if (presc_q == PW'(REFRESH - 1)) begin
         presc_d = '0;
         idx_d   = idx_q + 3'd1;
      end
   end

   // Digit select with leading-zero blanking; code 16 is the 't' glyph.
   always_comb begin
      code  = '0;
      blank = 1'b0;
      case (idx_q)
         3'd0: code = {1'b0, dig_q[3:0]};
         3'd1: begin
            code  = {1'b0, dig_q[7:4]};
            blank = (dig_q[19:4] == '0);
         end
         3'd2: begin
            code  = {1'b0, dig_q[11:8]};
            blank = (dig_q[19:8] == '0);
         end
         3'd3: begin
            code  = {1'b0, dig_q[15:12]};
            blank = (dig_q[19:12] == '0);
         end
         3'd4: begin
            code  = {1'b0, dig_q[19:16]};
            blank = (dig_q[19:16] == '0);
         end
         3'd5: blank = 1'b1;
         3'd6: code = {2'b00, prog};
         3'd7: code = gen_mod ? 5'h10 : 5'h0F;
         default: blank = 1'b1;
      endcase
   end

   always_comb begin
      case (code)
         5'h00:   seg = 8'b00000011;
         5'h01:   seg = 8'b10011111;
         5'h02:   seg = 8'b00100101;
         5'h03:   seg = 8'b00001101;
         5'h04:   seg = 8'b10011001;
         5'h05:   seg = 8'b01001001;
         5'h06:   seg = 8'b01000001;
         5'h07:   seg = 8'b00011111;
         5'h08:   seg = 8'b00000001;
         5'h09:   seg = 8'b00001001;
         5'h0A:   seg = 8'b00010001;
         5'h0B:   seg = 8'b11000001;
         5'h0C:   seg = 8'b01100011;
         5'h0D:   seg = 8'b10000101;
         5'h0E:   seg = 8'b01100001;
         5'h0F:   seg = 8'b01110001;
         5'h10:   seg = 8'b11100001;
         default: seg = 8'hFF;
      endcase
   end

   always_comb begin
      an_d  = ~(8'd1 << idx_q);
      cat_d = seg;
      if (blank) begin
         an_d  = 8'hFF;
         cat_d = 8'hFF;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q  <= S_IDLE;
         bin_q    <= '0;
         bcd_q    <= '0;
         cnt_q    <= '0;
         pend_v_q <= 1'b0;
         pend_q   <= '0;
         dig_q    <= '0;
         presc_q  <= '0;
         idx_q    <= '0;
         an_q     <= 8'hFF;
         cat_q    <= 8'hFF;
      end else begin
         state_q  <= state_d;
         bin_q    <= bin_d;
         bcd_q    <= bcd_d;
         cnt_q    <= cnt_d;
         pend_v_q <= pend_v_d;
         pend_q   <= pend_d;
         dig_q    <= dig_d;
         presc_q  <= presc_d;
         idx_q    <= idx_d;
         an_q     <= an_d;
         cat_q    <= cat_d;
      end
   end

   assign an      = an_q;
   assign dec_cat = cat_q;
   assign busy    = (state_q != S_IDLE);

endmodule

// File: tb/tb_seg_display_ctrl.sv
// Self-checking bench for seg_display_ctrl: decimal/segment reference model
// built from lit-segment letter lists and a scan position derived from elapsed cycles.
module tb_seg_display_ctrl;

   localparam int R = 4;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic        data_2_valid = 1'b0;
   logic [15:0] data_2 = '0;
   logic        gen_mod = 1'b0;
   logic [2:0]  prog = '0;
   logic [7:0]  an;
   logic [7:0]  dec_cat;
   logic        busy;

   int n_vec = 0;
   int n_err = 0;
   int k;

   seg_display_ctrl #(.REFRESH(R)) dut (
      .clock        (clock),
      .reset        (reset),
      .data_2_valid (data_2_valid),
      .data_2       (data_2),
      .gen_mod      (gen_mod),
      .prog         (prog),
      .an           (an),
      .dec_cat      (dec_cat),
      .busy         (busy)
   );

   always #5 clock = ~clock;

   // Cycles elapsed since reset release; the scan position follows from it.
   always @(posedge clock or negedge reset) begin
      if (!reset) k <= 0;
      else        k <= k + 1;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic string glyph(input int d);
      case (d)
         0:  return "abcdef";
         1:  return "bc";
         2:  return "abdeg";
         3:  return "abcdg";
         4:  return "bcfg";
         5:  return "acdfg";
         6:  return "acdefg";
         7:  return "abc";
         8:  return "abcdefg";
         9:  return "abcdfg";
         10: return "abcefg";
         11: return "cdefg";
         12: return "adef";
         13: return "bcdeg";
         14: return "adefg";
         15: return "aefg";
         default: return "defg";
      endcase
   endfunction

   function automatic logic [7:0] segs(input string s);
      logic [7:0] r;
      int b;
      r = 8'hFF;
      for (int i = 0; i < s.len(); i++) begin
         b = 7 - (int'(s[i]) - 97);
         r[b] = 1'b0;
      end
      return r;
   endfunction

   function automatic logic [15:0] exp_pair(input int idx, input int val, input int pr, input logic gm);
      logic       lit;
      int         d;
      int         p10;
      logic [7:0] ea;
      lit = 1'b1;
      d   = 0;
      p10 = 1;
      for (int i = 0; i < idx && i < 5; i++) p10 = p10 * 10;
      if (idx <= 4) begin
         d = (val / p10) % 10;
         if (idx > 0 && val < p10) lit = 1'b0;
      end else if (idx == 5) begin
         lit = 1'b0;
      end else if (idx == 6) begin
         d = pr;
      end else begin
         d = gm ? 16 : 15;
      end
      if (!lit) return 16'hFFFF;
      ea = ~(8'd1 << idx);
      return {ea, segs(glyph(d))};
   endfunction

   task automatic scan_check(input int val, input int ncyc, input string tag);
      int idx;
      logic [15:0] ex;
      for (int c = 0; c < ncyc; c++) begin
         @(negedge clock);
         idx = ((k - 1) / R) % 8;
         ex  = exp_pair(idx, val, int'(prog), gen_mod);
         n_vec++;
         if ({an, dec_cat} !== ex) begin
            n_err++;
            $display("FAIL %s val=%0d idx=%0d an,dec_cat got %h expected %h", tag, val, idx, {an, dec_cat}, ex);
         end
      end
   endtask

   task automatic convert(input int val, input string tag);
      int cnt;
      for (int i = 0; i < 100 && busy; i++) @(negedge clock);
      n_vec++;
      if (busy !== 1'b0) begin
         n_err++;
         $display("FAIL %s_idle busy got %b expected 0", tag, busy);
      end
      @(negedge clock);
      data_2       = 16'(val);
      data_2_valid = 1'b1;
      @(negedge clock);
      data_2_valid = 1'b0;
      cnt = 0;
      while (busy === 1'b1 && cnt < 100) begin
         cnt++;
         @(negedge clock);
      end
      n_vec++;
      if (cnt != 17) begin
         n_err++;
         $display("FAIL %s_busy_len val=%0d busy cycles got %0d expected 17", tag, val, cnt);
      end
      scan_check(val, 8 * R, tag);
   endtask

   task automatic test_reset();
      prog    = 3'($urandom_range(0, 7));
      gen_mod = 1'b0;
      reset   = 1'b0;
      repeat (3) @(negedge clock);
      n_vec++;
      if (an !== 8'hFF) begin
         n_err++;
         $display("FAIL reset_an got %h expected ff", an);
      end
      n_vec++;
      if (dec_cat !== 8'hFF) begin
         n_err++;
         $display("FAIL reset_dec_cat got %h expected ff", dec_cat);
      end
      n_vec++;
      if (busy !== 1'b0) begin
         n_err++;
         $display("FAIL reset_busy got %b expected 0", busy);
      end
      reset = 1'b1;
      @(negedge clock);
      n_vec++;
      if ({an, dec_cat} !== {8'hFE, 8'b00000011}) begin
         n_err++;
         $display("FAIL first_lit an,dec_cat got %h expected fe03", {an, dec_cat});
      end
      scan_check(0, 9 * R, "reset_scan");
   endtask

   task automatic test_max();
      prog    = 3'($urandom_range(0, 7));
      gen_mod = 1'($urandom_range(0, 1));
      convert(65535, "max");
   endtask

   task automatic test_blanking();
      convert(7, "blank7");
   endtask

   task automatic test_gen_mod();
      gen_mod = 1'b1;
      prog    = 3'd5;
      convert(4321, "genmod_t");
      gen_mod = 1'b0;
      prog    = 3'd2;
      convert(50, "genmod_f");
   endtask

   task automatic test_random();
      int bnd[10] = '{0, 9, 10, 99, 100, 999, 1000, 9999, 10000, 65535};
      int v;
      for (int it = 0; it < 16; it++) begin
         prog    = 3'($urandom_range(0, 7));
         gen_mod = 1'($urandom_range(0, 1));
         if (it < 10) v = bnd[$urandom_range(0, 9)];
         else         v = int'($urandom_range(0, 65535));
         convert(v, "random");
      end
   endtask

   task automatic test_back_to_back();
      logic bexp;
      int idx;
      logic [15:0] ex;
      for (int i = 0; i < 100 && busy; i++) @(negedge clock);
      @(negedge clock);
      data_2       = 16'd12;
      data_2_valid = 1'b1;
      for (int j = 0; j < 44; j++) begin
         @(negedge clock);
         case (j)
            0: data_2_valid = 1'b0;
            1: begin data_2 = 16'd34; data_2_valid = 1'b1; end
            2: begin data_2 = 16'd56; data_2_valid = 1'b1; end
            3: data_2_valid = 1'b0;
            default: ;
         endcase
         // 12 commits 17 cycles after its capture, 56 commits 18 cycles after that.
         bexp = (j < 17) || (j >= 18 && j < 35);
         n_vec++;
         if (busy !== bexp) begin
            n_err++;
            $display("FAIL b2b_busy cycle=%0d got %b expected %b", j, busy, bexp);
         end
         if (j >= 18) begin
            idx = ((k - 1) / R) % 8;
            ex  = exp_pair(idx, (j < 36) ? 12 : 56, int'(prog), gen_mod);
            n_vec++;
            if ({an, dec_cat} !== ex) begin
               n_err++;
               $display("FAIL b2b_display cycle=%0d idx=%0d got %h expected %h", j, idx, {an, dec_cat}, ex);
            end
         end
      end
      scan_check(56, 8 * R, "b2b_final");
   endtask

   task automatic test_mid_reset();
      for (int i = 0; i < 100 && busy; i++) @(negedge clock);
      @(negedge clock);
      data_2       = 16'd100;
      data_2_valid = 1'b1;
      @(negedge clock);
      data_2_valid = 1'b0;
      repeat (4) @(negedge clock);
      reset = 1'b0;
      #1;
      n_vec++;
      if (busy !== 1'b0) begin
         n_err++;
         $display("FAIL midreset_busy got %b expected 0", busy);
      end
      n_vec++;
      if ({an, dec_cat} !== 16'hFFFF) begin
         n_err++;
         $display("FAIL midreset_outputs got %h expected ffff", {an, dec_cat});
      end
      @(negedge clock);
      @(negedge clock);
      reset = 1'b1;
      for (int j = 0; j < 24; j++) begin
         @(negedge clock);
         n_vec++;
         if (busy !== 1'b0) begin
            n_err++;
            $display("FAIL midreset_no_commit cycle=%0d busy got %b expected 0", j, busy);
         end
      end
      scan_check(0, 8 * R, "midreset_scan");
   endtask

   initial begin
      test_reset();
      test_max();
      test_blanking();
      test_gen_mod();
      test_random();
      test_back_to_back();
      test_mid_reset();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
